// File: rtl/ccg_bist_response_reader.sv
// rtl/ccg_bist_response_reader.sv - LFSR stimulus / MISR response harness for one combinational netlist
// Optional abort input: define CCG_BIST_ABORT_EN.
module ccg_bist_response_reader #(
    parameter int              N_IN      = 20,
    parameter int              N_OUT     = 28,
    parameter int              SIG_W     = 32,
    parameter logic [SIG_W-1:0] MISR_POLY = 32'h04C11DB7,
    parameter int              PAT_CNT   = 1024,
    parameter int              DUT_LAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef CCG_BIST_ABORT_EN
    input  logic             abort,
`endif
    input  logic [N_IN-1:0]  seed,
    input  logic [SIG_W-1:0] golden_sig,
    output logic [N_IN-1:0]  pat_x,
    input  logic [N_OUT-1:0] dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int CW = $clog2(PAT_CNT + 1);
    localparam int VW = (DUT_LAT > 0) ? DUT_LAT : 1;
    localparam int DW = $clog2(VW + 1);
    localparam logic [CW-1:0] LAST_PAT   = CW'(PAT_CNT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(VW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q;
    logic [N_IN-1:0]  pat_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] gold_q;
    logic [CW-1:0]    cnt_q;
    logic [DW-1:0]    drn_q;
    logic [VW-1:0]    vld_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             abort_w;
    logic             upd;
    logic [N_IN-1:0]  lfsr_d;
    logic [SIG_W-1:0] misr_d;
    logic [VW-1:0]    vld_d;

`ifdef CCG_BIST_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        upd    = (DUT_LAT == 0) ? (state_q == S_RUN) : vld_q[VW-1];
        lfsr_d = {pat_q[N_IN-2:0], pat_q[N_IN-1] ^ pat_q[N_IN-4]};
        misr_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
               ^ SIG_W'(dut_f);
        // Each presented pattern enters the valid pipe; it qualifies the MISR update DUT_LAT cycles later.
        vld_d    = '0;
        vld_d[0] = (state_q == S_RUN);
        for (int i = 1; i < VW; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            sig_q   <= '0;
            gold_q  <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
            vld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        pat_q   <= (seed == '0) ? N_IN'(1) : seed;
                        sig_q   <= '0;
                        gold_q  <= golden_sig;
                        cnt_q   <= '0;
                        drn_q   <= '0;
                        vld_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort_w) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        vld_q   <= '0;
                    end else begin
                        if (upd) sig_q <= misr_d;
                        vld_q <= vld_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_PAT) begin
                            if (DUT_LAT == 0) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= (misr_d == gold_q);
                            end else begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            pat_q <= lfsr_d;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort_w) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        vld_q   <= '0;
                    end else begin
                        if (upd) sig_q <= misr_d;
                        vld_q <= vld_d;
                        drn_q <= drn_q + DW'(1);
                        if (drn_q == DRAIN_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (misr_d == gold_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pat_x     = pat_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_ccg_bist_response_reader.sv
// tb/tb_ccg_bist_response_reader.sv - directed self-checking bench for ccg_bist_response_reader
module tb_ccg_bist_response_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        abort_a = 1'b0, abort_b = 1'b0, abort_c = 1'b0;
    logic [19:0] seed_a = '0, seed_b = '0, seed_c = '0;
    logic [31:0] gold_a = '0, gold_b = '0, gold_c = '0;
    logic [27:0] f_a = '0, f_b = '0, f_c;
    logic [19:0] pat_a, pat_b, pat_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [31:0] sig_a, sig_b, sig_c;
    logic [19:0] dly1 = '0, dly2 = '0;

    int total = 0;
    int bad = 0;

    ccg_bist_response_reader #(.PAT_CNT(4), .DUT_LAT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef CCG_BIST_ABORT_EN
        .abort(abort_a),
`endif
        .seed(seed_a), .golden_sig(gold_a), .pat_x(pat_a), .dut_f(f_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

    ccg_bist_response_reader #(.PAT_CNT(2), .DUT_LAT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef CCG_BIST_ABORT_EN
        .abort(abort_b),
`endif
        .seed(seed_b), .golden_sig(gold_b), .pat_x(pat_b), .dut_f(f_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

    ccg_bist_response_reader #(.PAT_CNT(3), .DUT_LAT(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
`ifdef CCG_BIST_ABORT_EN
        .abort(abort_c),
`endif
        .seed(seed_c), .golden_sig(gold_c), .pat_x(pat_c), .dut_f(f_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

    // Two-stage pipelined netlist model: f = pat_x delayed 2 cycles.
    always @(posedge clk) begin
        dly1 <= pat_c;
        dly2 <= dly1;
    end
    assign f_c = {8'h00, dly2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    int nb;
    logic seen;

    initial begin
        tick();
        tick();
        chk("rst_pat", pat_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_sig", sig_a, 0);
        rst_n = 1'b1;
        tick();

        // seed=1, PAT_CNT=4
        seed_a = 20'h1; f_a = '0; gold_a = 32'h0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("a_pat0", pat_a, 20'h00001);
        chk("a_busy", busy_a, 1);
        tick(); chk("a_pat1", pat_a, 20'h00002);
        tick(); chk("a_pat2", pat_a, 20'h00004);
        tick(); chk("a_pat3", pat_a, 20'h00008);
        chk("a_done_c4", done_a, 0);
        tick();
        chk("a_done_c5", done_a, 1);
        chk("a_busy_c5", busy_a, 0);
        chk("a_pass", pass_a, 1);
        chk("a_sig", sig_a, 0);
        tick();
        chk("a_done_hold", done_a, 1);

        // seed=0 replaced by 1; start mid-run ignored
        seed_a = 20'h0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("z_pat0", pat_a, 20'h00001);
        chk("z_done_clr", done_a, 0);
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("z_pat2_ign", pat_a, 20'h00004);
        tick(); tick();
        chk("z_done", done_a, 1);
        chk("z_sig", sig_a, 0);
        chk("z_pass", pass_a, 1);

        // dut_f=1, PAT_CNT=2
        seed_b = 20'h5; f_b = 28'h0000001; gold_b = 32'h3;
        start_b = 1'b1; tick(); start_b = 1'b0;
        n = 1;
        while (!done_b && n < 40) begin tick(); n++; end
        chk("b_lat", n, 3);
        chk("b_sig", sig_b, 32'h3);
        chk("b_pass", pass_b, 1);
        gold_b = 32'h2;
        start_b = 1'b1; tick(); start_b = 1'b0;
        n = 1;
        while (!done_b && n < 40) begin tick(); n++; end
        chk("b2_lat", n, 3);
        chk("b2_sig", sig_b, 32'h3);
        chk("b2_pass", pass_b, 0);

        // DUT_LAT=2, PAT_CNT=3, patterns 0x80001,0x00003,0x00006
        seed_c = 20'h80001; gold_c = 32'h00200004;
        start_c = 1'b1; tick(); start_c = 1'b0;
        n = 1; nb = 0;
        while (!done_c && n < 40) begin
            if (busy_c) nb++;
            if (n == 5) chk("c_drain_pat", pat_c, 20'h00006);
            tick(); n++;
        end
        chk("c_lat", n, 6);
        chk("c_busy_cyc", nb, 5);
        chk("c_sig", sig_c, 32'h00200004);
        chk("c_pass", pass_c, 1);

        // reset mid-run
        seed_a = 20'h3; f_a = 28'h5;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("r_pat", pat_a, 0);
        chk("r_busy", busy_a, 0);
        chk("r_done", done_a, 0);
        chk("r_pass", pass_a, 0);
        chk("r_sig", sig_a, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); seen |= done_a; end
        chk("r_no_done", seen, 0);

`ifdef CCG_BIST_ABORT_EN
        seed_a = 20'h1; f_a = 28'h1; gold_a = 32'hF;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        abort_a = 1'b1; tick(); abort_a = 1'b0;
        chk("ab_busy", busy_a, 0);
        chk("ab_done", done_a, 0);
        chk("ab_sig", sig_a, 32'h1);
        tick(); tick(); tick();
        chk("ab_sig_frz", sig_a, 32'h1);
        chk("ab_done2", done_a, 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        n = 1;
        while (!done_a && n < 40) begin tick(); n++; end
        chk("ab_re_lat", n, 5);
        chk("ab_re_sig", sig_a, 32'hF);
        chk("ab_re_pass", pass_a, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
